// File: rtl/seg7_io_display.sv
// ---------------------------------------------------------------------------
// seg7_io_display
//   Reads the value held in a memory-mapped CPU output port and shows it in
//   decimal on an 8-digit, time-multiplexed, active-low seven-segment display.
//   A new value is converted to BCD by a sequential double-dabble converter,
//   which takes one bit per clock (32 cycles per conversion).
//
// Parameters
//   SCAN_DIV : number of clock cycles each digit stays enabled (2 .. 2^20)
//   LZ_BLANK : 1 = blank leading zeros (digit 0 is always shown)
//
// Ports
//   clock    in   single clock; all state updates on the rising edge
//   reset    in   synchronous, active-high
//   value_in in   32-bit unsigned value from the I/O output port register
//   blank    in   1 = all digit enables off (internal state keeps running)
//   an_n     out  8 active-low digit enables, bit i = decimal digit i
//   seg_n    out  7 active-low segments, bit0 = a ... bit6 = g
//   busy     out  high while a conversion is in progress
// ---------------------------------------------------------------------------
module seg7_io_display #(
    parameter int SCAN_DIV = 50000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] value_in,
    input  logic        blank,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        busy
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t        state_q;
    logic [31:0]   last_value_q;
    logic [31:0]   shift_q, shift_d;
    logic [39:0]   bcd_q, bcd_d;
    logic [39:0]   bcd_adj;
    logic [4:0]    bit_cnt_q;
    logic [31:0]   disp_digits_q;
    logic          ovf_q;
    logic [PW-1:0] prescaler_q;
    logic [2:0]    scan_idx_q;

    // One double-dabble iteration: add 3 to each BCD nibble >= 5, then
    // shift the combined {bcd, shift} register left by one bit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            last_value_q  <= 32'd0;
            shift_q       <= 32'd0;
            bcd_q         <= 40'd0;
            bit_cnt_q     <= 5'd0;
            disp_digits_q <= 32'd0;
            ovf_q         <= 1'b0;
            prescaler_q   <= '0;
            scan_idx_q    <= 3'd0;
        end else begin
            // The digit scan runs free of the converter and of blank.
            if (prescaler_q == PRESC_LAST) begin
                prescaler_q <= '0;
                scan_idx_q  <= scan_idx_q + 3'd1;
            end else begin
                prescaler_q <= prescaler_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    // A value that changed during a conversion differs from
                    // last_value here, so it is picked up on this edge.
                    if (value_in != last_value_q) begin
                        shift_q      <= value_in;
                        last_value_q <= value_in;
                        bcd_q        <= 40'd0;
                        bit_cnt_q    <= 5'd0;
                        state_q      <= CONV;
                    end
                end
                CONV: begin
                    shift_q   <= shift_d;
                    bcd_q     <= bcd_d;
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd31) begin
                        disp_digits_q <= bcd_d[31:0];
                        ovf_q         <= |bcd_d[39:32];
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == CONV);

    // Display outputs come from registers only; value_in never reaches them.
    logic [3:0] cur_digit;
    logic       upper_zero;

    assign cur_digit = disp_digits_q[{scan_idx_q, 2'b00} +: 4];

    // True when the selected digit and every digit above it are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i >= int'(scan_idx_q) && disp_digits_q[4*i +: 4] != 4'd0)
                upper_zero = 1'b0;
        end
    end

    assign an_n = blank ? 8'hFF : ~(8'b1 << scan_idx_q);

    always_comb begin
        seg_n = 7'h7F;
        if (ovf_q) begin
            seg_n = 7'h3F;
        end else if (LZ_BLANK && scan_idx_q != 3'd0 && upper_zero) begin
            seg_n = 7'h7F;
        end else begin
            case (cur_digit)
                4'd0:    seg_n = 7'h40;
                4'd1:    seg_n = 7'h79;
                4'd2:    seg_n = 7'h24;
                4'd3:    seg_n = 7'h30;
                4'd4:    seg_n = 7'h19;
                4'd5:    seg_n = 7'h12;
                4'd6:    seg_n = 7'h02;
                4'd7:    seg_n = 7'h78;
                4'd8:    seg_n = 7'h00;
                4'd9:    seg_n = 7'h10;
                default: seg_n = 7'h7F;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_io_display.sv
module tb_seg7_io_display;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] value_in = 32'd0;
    logic        blank = 1'b0;
    logic [7:0]  an_n0, an_n1;
    logic [6:0]  seg_n0, seg_n1;
    logic        busy0, busy1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;   // edges since the last reset edge

    always #5 clock = ~clock;

    seg7_io_display #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) u_lz (
        .clock(clock), .reset(reset), .value_in(value_in), .blank(blank),
        .an_n(an_n0), .seg_n(seg_n0), .busy(busy0));

    seg7_io_display #(.SCAN_DIV(4), .LZ_BLANK(1'b0)) u_nolz (
        .clock(clock), .reset(reset), .value_in(value_in), .blank(blank),
        .an_n(an_n1), .seg_n(seg_n1), .busy(busy1));

    function automatic int exp_idx();
        return (cyc / 4) % 8;
    endfunction

    function automatic logic [7:0] exp_an();
        logic [7:0] one;
        one = 8'b1;
        return ~(one << exp_idx());
    endfunction

    task automatic step();
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        cyc = 0;
    endtask

    // Advance until the scan model says digit k is selected (bounded).
    task automatic wait_digit(input int k, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (exp_idx() == k) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Counts cycles with busy high after a new value is applied (bounded).
    task automatic wait_conv(output int n);
        n = 0;
        step();
        while (busy0 && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        value_in = 32'd0;
        blank = 1'b0;
        do_reset();
        for (int n = 0; n < 100; n++) begin
            checks++;
            if (an_n0 !== exp_an() || busy0 !== 1'b0 ||
                seg_n0 !== ((exp_idx() == 0) ? 7'h40 : 7'h7F) || seg_n1 !== 7'h40) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d: an=%h seg=%h/%h busy=%b exp an=%h",
                         n, an_n0, seg_n0, seg_n1, busy0, exp_an());
            end
            step();
        end
    endtask

    task automatic test_convert();
        int n;
        bit ok;
        value_in = 32'd12345678;
        wait_conv(n);
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL conv_busy_len: got %0d exp 32", n);
        end
        wait_digit(0, ok);
        checks++;
        if (!ok || seg_n0 !== 7'h00 || seg_n1 !== 7'h00) begin
            errors++;
            $display("FAIL digit0_8: got %h exp 00", seg_n0);
        end
        wait_digit(3, ok);
        checks++;
        if (!ok || seg_n0 !== 7'h12) begin
            errors++;
            $display("FAIL digit3_5: got %h exp 12", seg_n0);
        end
        wait_digit(7, ok);
        checks++;
        if (!ok || seg_n0 !== 7'h79 || an_n0 !== 8'h7F) begin
            errors++;
            $display("FAIL digit7_1: got seg %h an %h exp 79/7F", seg_n0, an_n0);
        end
    endtask

    task automatic test_lz();
        int n;
        bit ok;
        value_in = 32'd42;
        wait_conv(n);
        wait_digit(0, ok);
        checks++;
        if (!ok || seg_n0 !== 7'h24) begin
            errors++;
            $display("FAIL lz_digit0: got %h exp 24", seg_n0);
        end
        wait_digit(1, ok);
        checks++;
        if (!ok || seg_n0 !== 7'h19) begin
            errors++;
            $display("FAIL lz_digit1: got %h exp 19", seg_n0);
        end
        for (int k = 2; k < 8; k++) begin
            wait_digit(k, ok);
            checks++;
            if (!ok || seg_n0 !== 7'h7F || seg_n1 !== 7'h40) begin
                errors++;
                $display("FAIL lz_digit%0d: got %h/%h exp 7F/40", k, seg_n0, seg_n1);
            end
        end
    endtask

    task automatic test_overflow();
        int n;
        bit ok;
        value_in = 32'd100000000;
        wait_conv(n);
        for (int k = 0; k < 8; k++) begin
            wait_digit(k, ok);
            checks++;
            if (!ok || seg_n0 !== 7'h3F || seg_n1 !== 7'h3F) begin
                errors++;
                $display("FAIL ovf_digit%0d: got %h/%h exp 3F", k, seg_n0, seg_n1);
            end
        end
        value_in = 32'd99999999;
        wait_conv(n);
        for (int k = 0; k < 8; k++) begin
            wait_digit(k, ok);
            checks++;
            if (!ok || seg_n0 !== 7'h10 || seg_n1 !== 7'h10) begin
                errors++;
                $display("FAIL max_digit%0d: got %h/%h exp 10", k, seg_n0, seg_n1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  total;
        int  falls;
        bit  prev;
        bit  ok;
        total = 0;
        falls = 0;
        prev  = 1'b1;
        value_in = 32'd5;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy0) total++;
        end
        value_in = 32'd7;
        for (int i = 0; i < 200 && falls < 2; i++) begin
            step();
            if (busy0) total++;
            if (prev && !busy0) begin
                falls++;
                if (falls == 1) begin
                    checks++;
                    if (seg_n0 !== ((exp_idx() == 0) ? 7'h12 : 7'h7F) ||
                        seg_n1 !== ((exp_idx() == 0) ? 7'h12 : 7'h40)) begin
                        errors++;
                        $display("FAIL b2b_first_5: got %h/%h idx %0d", seg_n0, seg_n1, exp_idx());
                    end
                end
            end
            prev = busy0;
        end
        checks++;
        if (total !== 64 || falls !== 2) begin
            errors++;
            $display("FAIL b2b_busy_total: got %0d falls %0d exp 64/2", total, falls);
        end
        wait_digit(0, ok);
        checks++;
        if (!ok || seg_n0 !== 7'h78) begin
            errors++;
            $display("FAIL b2b_final_7: got %h exp 78", seg_n0);
        end
    endtask

    task automatic test_blank();
        blank = 1'b1;
        for (int n = 0; n < 40; n++) begin
            step();
            checks++;
            if (an_n0 !== 8'hFF || an_n1 !== 8'hFF) begin
                errors++;
                $display("FAIL blank_an: got %h/%h exp FF", an_n0, an_n1);
            end
        end
        blank = 1'b0;
        #1;
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (an_n0 !== exp_an()) begin
                errors++;
                $display("FAIL unblank_scan: got %h exp %h", an_n0, exp_an());
            end
            step();
        end
    endtask

    task automatic test_reset_mid_conv();
        value_in = 32'd123;
        step();
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_conv_start: busy %b exp 1", busy0);
        end
        for (int i = 0; i < 14; i++) step();
        reset = 1'b1;
        value_in = 32'd0;
        step();
        reset = 1'b0;
        cyc = 0;
        checks++;
        if (busy0 !== 1'b0 || an_n0 !== 8'hFE || seg_n0 !== 7'h40 || seg_n1 !== 7'h40) begin
            errors++;
            $display("FAIL mid_conv_reset: busy %b an %h seg %h/%h exp 0/FE/40",
                     busy0, an_n0, seg_n0, seg_n1);
        end
        for (int n = 0; n < 40; n++) begin
            step();
            checks++;
            if (busy0 !== 1'b0 || seg_n1 !== 7'h40) begin
                errors++;
                $display("FAIL after_reset_zero: busy %b seg %h exp 0/40", busy0, seg_n1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_lz();
        test_overflow();
        test_back_to_back();
        test_blank();
        test_reset_mid_conv();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_io_display.md
# seg7_io_display

Memory-mapped output consumer for the pipelined CPU's I/O space. Takes a 32-bit value written by the CPU to an output port and converts it to 8 decimal digits with a sequential double-dabble converter. Drives a time-multiplexed, active-low 8-digit seven-segment display. Sits directly downstream of the memory stage's I/O output registers, one instance per displayed port.

## Interface
- SCAN_DIV, 50000: clock cycles each digit stays enabled; legal range 2..2^20.
- LZ_BLANK, 1: 1 = suppress leading zeros; digit 0 is never suppressed.

- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- value_in  in  32  unsigned value from the I/O output port register.
- blank  in  1  1 = all digit enables inactive; internal state keeps running.
- an_n  out  8  active-low digit enables; bit i = decimal digit i (bit 0 = units).
- seg_n  out  7  active-low segments; bit0=a … bit6=g.
- busy  out  1  high while a conversion is in progress.

## Operation
- Registers:
  - state (IDLE/CONV)
  - last_value[31:0]
  - shift[31:0]
  - bcd[39:0] (10 digits)
  - bit_cnt[4:0]
  - disp_digits[31:0] (8 digits)
  - ovf
  - prescaler
  - scan_idx[2:0]
- IDLE: each edge, compare value_in with last_value.
  - If different: shift←value_in, last_value←value_in, bcd←0, bit_cnt←0, state←CONV.
  - If equal: hold.
- CONV, one iteration per edge:
  - Add 3 to every bcd nibble ≥5.
  - Shift {bcd,shift} left by 1.
  - bit_cnt+1.
- On the edge where bit_cnt==31:
  - disp_digits←low 8 digits of the final bcd.
  - ovf←(bcd[39:32]≠0), i.e. value >99,999,999.
  - state←IDLE.
- value_in changes during CONV are ignored. The IDLE compare on the following edge picks them up, so the final displayed value always equals the last stable value_in.
- busy = (state==CONV).
- Scan:
  - prescaler counts 0..SCAN_DIV-1 and wraps.
  - At wrap, scan_idx increments modulo 8 (7→0).
- an_n:
  - blank=1: 8'hFF.
  - Otherwise: all ones except bit scan_idx = 0.
- seg_n, combinational decode of the selected digit d, in priority order:
  - ovf=1: 7'h3F (dash).
  - LZ_BLANK=1, scan_idx≠0, and disp_digits digits scan_idx..7 all zero: 7'h7F.
  - Otherwise, digit patterns 0..9: 40,79,24,30,19,12,02,78,00,10 (hex).
- an_n and seg_n are combinational from registers only. They have no path from value_in.

## Timing
- Reset values:
  - state IDLE, busy 0.
  - last_value 0, disp_digits 0, ovf 0.
  - prescaler 0, scan_idx 0.
  - an_n 8'hFE (blank=0), seg_n 7'h40.
- Because value_in==0 matches last_value after reset, no conversion starts until a nonzero write.
- Conversion latency:
  - Change captured at edge E; busy high after E.
  - disp_digits/ovf updated at edge E+32; busy low after E+32.
  - Earliest next capture is at E+33.
- Reset asserted mid-conversion: abort on that edge. All registers return to reset values and the old display is discarded.
- Reset has priority over every other update on the same edge.
- blank does not affect prescaler, scan_idx, or conversion.
- Digit dwell is exactly SCAN_DIV cycles. A full refresh is 8·SCAN_DIV cycles.
- The value 99,999,999 displays normally; 100,000,000 and above set ovf.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset held 2 cycles, then released with value_in=0 → an_n=FE, seg_n=40, busy=0 for 100 cycles. scan_idx steps every 4 cycles; an_n cycles FE,FD,…,7F,FE.
- value_in=12345678 → busy high exactly 32 cycles. Then digit0 seg_n=00 ('8'), digit3 seg_n=12 ('5'), digit7 seg_n=79 ('1').
- LZ_BLANK=1, value_in=42 → digit0=24, digit1=19, digits 2–7=7F. With LZ_BLANK=0, digits 2–7=40.
- value_in=100000000 → after conversion, all digits seg_n=3F. Then value_in=99999999 → all digits 10.
- value_in=5, then 7 at 10 cycles into the conversion → the first conversion shows '5'. A second conversion starts the edge after busy falls and ends showing '7'. Total busy cycles = 64.
- blank=1 during a scan → an_n=FF while scan_idx keeps advancing. Reset asserted 15 cycles into the conversion of 123 → busy=0 next edge and display shows '0'.
